conv_sched: RTL and testbench

Phase sequencer and memory-port arbiter for one convolution job. It starts the im2col unit, waits for its completion, then launches the systolic array. During each phase it hands the single shared scratchpad port to the active engine. It sits between the top-level job control and the im2col/systolic engines, and provides per-phase timeout detection and a job cycle counter.

---
 rtl/conv_sched.sv | 160 ++++++++++++++++
 tb/tb_conv_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// Phase sequencer for one convolution job: runs im2col, then the systolic array,
// handing the single scratchpad port to whichever engine owns the current phase.
module conv_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic                  rst_im2col,
    input  logic                  im2col_done,
    input  logic [ADDR_WIDTH-1:0] im_addr_rd,
    input  logic [ADDR_WIDTH-1:0] im_addr_wr,
    input  logic [DATA_WIDTH-1:0] im_data_wr,
    input  logic                  im_wr_en,
    output logic                  sa_start,
    input  logic                  sa_done,
    input  logic [ADDR_WIDTH-1:0] sa_addr_rd,
    input  logic [ADDR_WIDTH-1:0] sa_addr_wr,
    input  logic [DATA_WIDTH-1:0] sa_data_wr,
    input  logic                  sa_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr_wr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_data_rd,
    output logic [DATA_WIDTH-1:0] im_data_rd,
    output logic [DATA_WIDTH-1:0] sa_data_rd
);

    localparam int                PTMR_W    = $clog2(TIMEOUT);
    localparam logic [PTMR_W-1:0] PTMR_LAST = PTMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IM2COL,
        S_GAP,
        S_SA_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [PTMR_W-1:0]     ptmr_q, ptmr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  rst_im2col_q, rst_im2col_d;
    logic                  sa_start_q, sa_start_d;

    // NOTE: every sequential element uses <= so all registers sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptmr_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rst_im2col_q <= 1'b1;
            sa_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptmr_q       <= ptmr_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rst_im2col_q <= rst_im2col_d;
            sa_start_q   <= sa_start_d;
        end
    end

    // NOTE: each comb block assigns a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_IM2COL;
            // The im2col done flag can be stale on the first cycle, so ptmr==0 is skipped.
            S_IM2COL: begin
                if (im2col_done && (ptmr_q != '0)) state_d = S_GAP;
                else if (ptmr_q == PTMR_LAST)      state_d = S_ERR;
            end
            S_GAP:    state_d = S_SA_RUN;
            S_SA_RUN: begin
                if (sa_done)                  state_d = S_DONE;
                else if (ptmr_q == PTMR_LAST) state_d = S_ERR;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERR:    if (start) state_d = S_IM2COL;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptmr_d = ptmr_q;
        if (state_d != state_q)
            ptmr_d = '0;
        else if ((state_q == S_IM2COL) || (state_q == S_SA_RUN))
            ptmr_d = ptmr_q + PTMR_W'(1);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (((state_q == S_IDLE) || (state_q == S_ERR)) && (state_d == S_IM2COL))
            cnt_d = '0;
        else if (busy_q && !(&cnt_q))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Control outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        busy_d       = (state_d == S_IM2COL) || (state_d == S_GAP) ||
                       (state_d == S_SA_RUN) || (state_d == S_DONE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
        sa_start_d   = (state_d == S_GAP);
        rst_im2col_d = (state_d != S_IM2COL);
    end

    always_comb begin
        mem_addr_rd = '0;
        mem_addr_wr = '0;
        mem_data_wr = '0;
        mem_wr_en   = 1'b0;
        case (state_q)
            S_IM2COL: begin
                mem_addr_rd = im_addr_rd;
                mem_addr_wr = im_addr_wr;
                mem_data_wr = im_data_wr;
                mem_wr_en   = im_wr_en;
            end
            S_SA_RUN: begin
                mem_addr_rd = sa_addr_rd;
                mem_addr_wr = sa_addr_wr;
                mem_data_wr = sa_data_wr;
                mem_wr_en   = sa_wr_en;
            end
            default: ;
        endcase
    end

    assign im_data_rd = mem_data_rd;
    assign sa_data_rd = mem_data_rd;

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cycle_cnt  = cnt_q;
    assign rst_im2col = rst_im2col_q;
    assign sa_start   = sa_start_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: main instance for job flow and arbitration,
// a second instance with TIMEOUT=16 for the timeout paths.
module tb_conv_sched;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          start, im2col_done, sa_done;
    logic [AW-1:0] im_addr_rd, im_addr_wr, sa_addr_rd, sa_addr_wr;
    logic [DW-1:0] im_data_wr, sa_data_wr, mem_data_rd;
    logic          im_wr_en, sa_wr_en;

    logic          busy, done, err, rst_im2col, sa_start, mem_wr_en;
    logic [CW-1:0] cycle_cnt;
    logic [AW-1:0] mem_addr_rd, mem_addr_wr;
    logic [DW-1:0] mem_data_wr, im_data_rd, sa_data_rd;

    logic          t_start, t_im_done, t_sa_done;
    logic          t_busy, t_done, t_err, t_rst_im2col, t_sa_start, t_mem_wr_en;
    logic [CW-1:0] t_cycle_cnt;
    logic [AW-1:0] t_mem_addr_rd, t_mem_addr_wr;
    logic [DW-1:0] t_mem_data_wr, t_im_data_rd, t_sa_data_rd;

    int errors = 0;
    int checks = 0;

    conv_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(64), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .cycle_cnt(cycle_cnt), .rst_im2col(rst_im2col), .im2col_done(im2col_done),
        .im_addr_rd(im_addr_rd), .im_addr_wr(im_addr_wr), .im_data_wr(im_data_wr),
        .im_wr_en(im_wr_en), .sa_start(sa_start), .sa_done(sa_done),
        .sa_addr_rd(sa_addr_rd), .sa_addr_wr(sa_addr_wr), .sa_data_wr(sa_data_wr),
        .sa_wr_en(sa_wr_en), .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr),
        .mem_data_wr(mem_data_wr), .mem_wr_en(mem_wr_en), .mem_data_rd(mem_data_rd),
        .im_data_rd(im_data_rd), .sa_data_rd(sa_data_rd)
    );

    conv_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16), .CNT_WIDTH(CW)) u_tmo (
        .clk(clk), .rst_n(rst_n), .start(t_start), .busy(t_busy), .done(t_done), .err(t_err),
        .cycle_cnt(t_cycle_cnt), .rst_im2col(t_rst_im2col), .im2col_done(t_im_done),
        .im_addr_rd(im_addr_rd), .im_addr_wr(im_addr_wr), .im_data_wr(im_data_wr),
        .im_wr_en(im_wr_en), .sa_start(t_sa_start), .sa_done(t_sa_done),
        .sa_addr_rd(sa_addr_rd), .sa_addr_wr(sa_addr_wr), .sa_data_wr(sa_data_wr),
        .sa_wr_en(sa_wr_en), .mem_addr_rd(t_mem_addr_rd), .mem_addr_wr(t_mem_addr_wr),
        .mem_data_wr(t_mem_data_wr), .mem_wr_en(t_mem_wr_en), .mem_data_rd(mem_data_rd),
        .im_data_rd(t_im_data_rd), .sa_data_rd(t_sa_data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; im2col_done = 1'b0; sa_done = 1'b0;
        t_start = 1'b0; t_im_done = 1'b0; t_sa_done = 1'b0;
        im_addr_rd = 32'h11; im_addr_wr = 32'h22; im_data_wr = 8'h33; im_wr_en = 1'b1;
        sa_addr_rd = 32'h44; sa_addr_wr = 32'h55; sa_data_wr = 8'h66; sa_wr_en = 1'b1;
        mem_data_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b need 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b need 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b need 0", err); end
        checks++; if (rst_im2col !== 1'b1) begin errors++; $display("FAIL reset rst_im2col: got %b need 1", rst_im2col); end
        checks++; if (sa_start !== 1'b0) begin errors++; $display("FAIL reset sa_start: got %b need 0", sa_start); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset cycle_cnt: got %0d need 0", cycle_cnt); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset mem_wr_en: got %b need 0", mem_wr_en); end
        checks++; if (mem_addr_wr !== 32'd0) begin errors++; $display("FAIL reset mem_addr_wr: got %h need 0", mem_addr_wr); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset idle busy: got %b need 0", busy); end
        checks++; if (rst_im2col !== 1'b1) begin errors++; $display("FAIL reset idle rst_im2col: got %b need 1", rst_im2col); end
    endtask

    // start at 0, im2col_done at 10, sa_done at 30
    task automatic test_nominal();
        logic e_busy, e_done, e_sas, e_rst;
        for (int cyc = 0; cyc <= 32; cyc++) begin
            e_busy = (cyc >= 1) && (cyc <= 31);
            e_done = (cyc == 31);
            e_sas  = (cyc == 11);
            e_rst  = !((cyc >= 1) && (cyc <= 10));
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL nominal busy cyc=%0d: got %b need %b", cyc, busy, e_busy); end
            checks++; if (done !== e_done) begin errors++; $display("FAIL nominal done cyc=%0d: got %b need %b", cyc, done, e_done); end
            checks++; if (sa_start !== e_sas) begin errors++; $display("FAIL nominal sa_start cyc=%0d: got %b need %b", cyc, sa_start, e_sas); end
            checks++; if (rst_im2col !== e_rst) begin errors++; $display("FAIL nominal rst_im2col cyc=%0d: got %b need %b", cyc, rst_im2col, e_rst); end
            if (cyc == 32) begin
                checks++; if (cycle_cnt !== 32'd31) begin errors++; $display("FAIL nominal cycle_cnt: got %0d need 31", cycle_cnt); end
            end
            start = (cyc == 0);
            im2col_done = (cyc >= 10);
            sa_done = (cyc >= 30);
            step();
        end
        start = 1'b0; im2col_done = 1'b0; sa_done = 1'b0;
    endtask

    // start at 0, im2col_done at 5 -> GAP 6, SA_RUN 7..9, sa_done at 9 -> DONE 10
    task automatic test_arbitration();
        logic          im_ph, sa_ph;
        logic [AW-1:0] e_awr, e_ard;
        logic [DW-1:0] e_dwr, rd_val;
        im_addr_rd = 32'h2100; im_addr_wr = 32'h2000; im_data_wr = 8'h21; im_wr_en = 1'b1;
        sa_addr_rd = 32'h3100; sa_addr_wr = 32'h3000; sa_data_wr = 8'h31; sa_wr_en = 1'b1;
        for (int cyc = 0; cyc <= 11; cyc++) begin
            im_ph = (cyc >= 1) && (cyc <= 5);
            sa_ph = (cyc >= 7) && (cyc <= 9);
            e_awr = im_ph ? 32'h2000 : (sa_ph ? 32'h3000 : 32'h0);
            e_ard = im_ph ? 32'h2100 : (sa_ph ? 32'h3100 : 32'h0);
            e_dwr = im_ph ? 8'h21 : (sa_ph ? 8'h31 : 8'h00);
            checks++; if (mem_addr_wr !== e_awr) begin errors++; $display("FAIL arb mem_addr_wr cyc=%0d: got %h need %h", cyc, mem_addr_wr, e_awr); end
            checks++; if (mem_addr_rd !== e_ard) begin errors++; $display("FAIL arb mem_addr_rd cyc=%0d: got %h need %h", cyc, mem_addr_rd, e_ard); end
            checks++; if (mem_data_wr !== e_dwr) begin errors++; $display("FAIL arb mem_data_wr cyc=%0d: got %h need %h", cyc, mem_data_wr, e_dwr); end
            checks++; if (mem_wr_en !== (im_ph || sa_ph)) begin errors++; $display("FAIL arb mem_wr_en cyc=%0d: got %b need %b", cyc, mem_wr_en, im_ph || sa_ph); end
            start = (cyc == 0);
            im2col_done = (cyc >= 5);
            sa_done = (cyc >= 9);
            rd_val = 8'(cyc * 37 + 5);
            mem_data_rd = rd_val;
            #1;
            checks++; if (im_data_rd !== rd_val) begin errors++; $display("FAIL arb im_data_rd cyc=%0d: got %h need %h", cyc, im_data_rd, rd_val); end
            checks++; if (sa_data_rd !== rd_val) begin errors++; $display("FAIL arb sa_data_rd cyc=%0d: got %h need %h", cyc, sa_data_rd, rd_val); end
            step();
        end
        start = 1'b0; im2col_done = 1'b0; sa_done = 1'b0;
    endtask

    // im2col_done already high at start: ptmr==0 cycle ignored, GAP at 3, DONE at 6
    task automatic test_stale_done();
        logic e_rst, e_busy, e_wen;
        im2col_done = 1'b1;
        for (int cyc = 0; cyc <= 7; cyc++) begin
            e_rst  = !((cyc >= 1) && (cyc <= 2));
            e_busy = (cyc >= 1) && (cyc <= 6);
            e_wen  = ((cyc >= 1) && (cyc <= 2)) || ((cyc >= 4) && (cyc <= 5));
            checks++; if (rst_im2col !== e_rst) begin errors++; $display("FAIL stale rst_im2col cyc=%0d: got %b need %b", cyc, rst_im2col, e_rst); end
            checks++; if (sa_start !== (cyc == 3)) begin errors++; $display("FAIL stale sa_start cyc=%0d: got %b need %b", cyc, sa_start, cyc == 3); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL stale busy cyc=%0d: got %b need %b", cyc, busy, e_busy); end
            checks++; if (done !== (cyc == 6)) begin errors++; $display("FAIL stale done cyc=%0d: got %b need %b", cyc, done, cyc == 6); end
            checks++; if (mem_wr_en !== e_wen) begin errors++; $display("FAIL stale mem_wr_en cyc=%0d: got %b need %b", cyc, mem_wr_en, e_wen); end
            if (cyc == 7) begin
                checks++; if (cycle_cnt !== 32'd6) begin errors++; $display("FAIL stale cycle_cnt: got %0d need 6", cycle_cnt); end
            end
            start = (cyc == 0);
            sa_done = (cyc >= 5);
            step();
        end
        start = 1'b0; im2col_done = 1'b0; sa_done = 1'b0;
    endtask

    // start pulses during SA_RUN (7, 9) and DONE (13) must be ignored
    task automatic test_ignored_start();
        logic e_busy, e_rst;
        for (int cyc = 0; cyc <= 15; cyc++) begin
            e_busy = (cyc >= 1) && (cyc <= 13);
            e_rst  = !((cyc >= 1) && (cyc <= 4));
            checks++; if (sa_start !== (cyc == 5)) begin errors++; $display("FAIL ignstart sa_start cyc=%0d: got %b need %b", cyc, sa_start, cyc == 5); end
            checks++; if (done !== (cyc == 13)) begin errors++; $display("FAIL ignstart done cyc=%0d: got %b need %b", cyc, done, cyc == 13); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL ignstart busy cyc=%0d: got %b need %b", cyc, busy, e_busy); end
            checks++; if (rst_im2col !== e_rst) begin errors++; $display("FAIL ignstart rst_im2col cyc=%0d: got %b need %b", cyc, rst_im2col, e_rst); end
            if (cyc >= 14) begin
                checks++; if (cycle_cnt !== 32'd13) begin errors++; $display("FAIL ignstart cycle_cnt cyc=%0d: got %0d need 13", cyc, cycle_cnt); end
            end
            start = (cyc == 0) || (cyc == 7) || (cyc == 9) || (cyc == 13);
            im2col_done = (cyc >= 4);
            sa_done = (cyc >= 12);
            step();
        end
        start = 1'b0; im2col_done = 1'b0; sa_done = 1'b0;
    endtask

    // TIMEOUT=16: IM2COL timeout at 17, restart at 18, im2col_done exactly at ptmr==15
    // (cycle 34) wins over timeout, then SA_RUN times out at cycle 52.
    task automatic test_timeout();
        logic e_err, e_busy, e_rst, e_wen;
        for (int cyc = 0; cyc <= 52; cyc++) begin
            e_err  = ((cyc >= 17) && (cyc <= 18)) || (cyc >= 52);
            e_busy = ((cyc >= 1) && (cyc <= 16)) || ((cyc >= 19) && (cyc <= 51));
            e_rst  = !(((cyc >= 1) && (cyc <= 16)) || ((cyc >= 19) && (cyc <= 34)));
            e_wen  = ((cyc >= 1) && (cyc <= 16)) || ((cyc >= 19) && (cyc <= 34)) ||
                     ((cyc >= 36) && (cyc <= 51));
            checks++; if (t_err !== e_err) begin errors++; $display("FAIL timeout err cyc=%0d: got %b need %b", cyc, t_err, e_err); end
            checks++; if (t_busy !== e_busy) begin errors++; $display("FAIL timeout busy cyc=%0d: got %b need %b", cyc, t_busy, e_busy); end
            checks++; if (t_rst_im2col !== e_rst) begin errors++; $display("FAIL timeout rst_im2col cyc=%0d: got %b need %b", cyc, t_rst_im2col, e_rst); end
            checks++; if (t_sa_start !== (cyc == 35)) begin errors++; $display("FAIL timeout sa_start cyc=%0d: got %b need %b", cyc, t_sa_start, cyc == 35); end
            checks++; if (t_done !== 1'b0) begin errors++; $display("FAIL timeout done cyc=%0d: got %b need 0", cyc, t_done); end
            checks++; if (t_mem_wr_en !== e_wen) begin errors++; $display("FAIL timeout mem_wr_en cyc=%0d: got %b need %b", cyc, t_mem_wr_en, e_wen); end
            if (cyc == 17 || cyc == 18) begin
                checks++; if (t_cycle_cnt !== 32'd16) begin errors++; $display("FAIL timeout cycle_cnt cyc=%0d: got %0d need 16", cyc, t_cycle_cnt); end
            end
            if (cyc == 19) begin
                checks++; if (t_cycle_cnt !== 32'd0) begin errors++; $display("FAIL timeout restart cycle_cnt: got %0d need 0", t_cycle_cnt); end
            end
            if (cyc == 52) begin
                checks++; if (t_cycle_cnt !== 32'd33) begin errors++; $display("FAIL timeout sa cycle_cnt: got %0d need 33", t_cycle_cnt); end
            end
            t_start = (cyc == 0) || (cyc == 18);
            t_im_done = (cyc >= 34);
            step();
        end
        t_start = 1'b0; t_im_done = 1'b0;
    endtask

    // start at 0, im2col_done at 3 -> SA_RUN from 5; rst_n dropped mid-cycle 8
    task automatic test_async_reset();
        for (int cyc = 0; cyc <= 7; cyc++) begin
            start = (cyc == 0);
            im2col_done = (cyc >= 3);
            step();
        end
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset pre busy: got %b need 1", busy); end
        checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL areset pre mem_wr_en: got %b need 1", mem_wr_en); end
        checks++; if (mem_addr_wr !== 32'h3000) begin errors++; $display("FAIL areset pre mem_addr_wr: got %h need 3000", mem_addr_wr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset busy: got %b need 0", busy); end
        checks++; if (rst_im2col !== 1'b1) begin errors++; $display("FAIL areset rst_im2col: got %b need 1", rst_im2col); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL areset mem_wr_en: got %b need 0", mem_wr_en); end
        checks++; if (mem_addr_wr !== 32'h0) begin errors++; $display("FAIL areset mem_addr_wr: got %h need 0", mem_addr_wr); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL areset cycle_cnt: got %0d need 0", cycle_cnt); end
        checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL areset tmo err: got %b need 0", t_err); end
        rst_n = 1'b1;
        im2col_done = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset idle busy: got %b need 0", busy); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset restart busy: got %b need 1", busy); end
        checks++; if (rst_im2col !== 1'b0) begin errors++; $display("FAIL areset restart rst_im2col: got %b need 0", rst_im2col); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_arbitration();
        test_stale_done();
        test_ignored_start();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
